pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_ADDR_LEN, default 5, register-address width.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 15, maximum MEM_WAIT cycles before error.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port id_src1  input  REG_ADDR_LEN  ID-stage source 1 address.
REQ-006 SHALL have port id_src2  input  REG_ADDR_LEN  ID-stage source 2 address.
REQ-007 SHALL have port id_two_src  input  1  ID instruction reads src2 (R-type, store, BNE).
REQ-008 SHALL have port id_br_taken  input  1  ID-stage branch resolved taken.
REQ-009 SHALL have port exe_dest  input  REG_ADDR_LEN  EXE-stage destination address.
REQ-010 SHALL have port exe_mem_r_en  input  1  EXE-stage instruction is a load.
REQ-011 SHALL have port mem_req  input  1  MEM-stage instruction accesses data memory.
REQ-012 SHALL have port mem_ready  input  1  data memory completes access this cycle.
REQ-013 SHALL have port hazard_detected  output  1  insert bubble into ID/EXE; drives ID-stage controller.
REQ-014 SHALL have port pc_freeze  output  1  hold PC.
REQ-015 SHALL have port ifid_freeze  output  1  hold IF/ID register.
REQ-016 SHALL have port ifid_flush  output  1  zero IF/ID register.
REQ-017 SHALL have port pipe_freeze  output  1  hold ID/EXE, EXE/MEM, MEM/WB registers.
REQ-018 SHALL have port mem_timeout  output  1  sticky memory-timeout error.
REQ-019 SHALL have port stall_cnt  output  16  saturating count of stall cycles.
REQ-020 SHALL have port flush_cnt  output  16  saturating count of branch flushes.

Function
REQ-021 SHALL implement FSM states RUN, MEM_WAIT, ERROR; control outputs are combinational from inputs and registered state (zero-cycle latency).
REQ-022 RUN -> MEM_WAIT when mem_req=1 and mem_ready=0; otherwise stay RUN.
REQ-023 MEM_WAIT -> RUN when mem_ready=1; MEM_WAIT -> ERROR when wait counter equals MEM_TIMEOUT-1 and mem_ready=0; ERROR held until rst.
REQ-024 Wait counter SHALL clear on entry to MEM_WAIT and increment each MEM_WAIT cycle with mem_ready=0.
REQ-025 mem_freeze term = (RUN and mem_req and !mem_ready) or (MEM_WAIT and !mem_ready) or ERROR.
REQ-026 When mem_freeze=1: pc_freeze=ifid_freeze=pipe_freeze=1, hazard_detected=0, ifid_flush=0.
REQ-027 load_use term = exe_mem_r_en and exe_dest!=0 and (id_src1==exe_dest or (id_two_src and id_src2==exe_dest)).
REQ-028 When mem_freeze=0 and load_use=1: hazard_detected=pc_freeze=ifid_freeze=1, ifid_flush=0, pipe_freeze=0.
REQ-029 When mem_freeze=0, load_use=0, id_br_taken=1: ifid_flush=1, all others 0.
REQ-030 Priority SHALL be ERROR > mem_freeze > load_use > branch flush; suppressed branch is re-evaluated next cycle.
REQ-031 stall_cnt SHALL increment each cycle pc_freeze=1, saturating at 0xFFFF.
REQ-032 flush_cnt SHALL increment each cycle ifid_flush=1, saturating at 0xFFFF.
REQ-033 mem_timeout SHALL be 1 exactly while state is ERROR.

Reset
REQ-034 On rst=1 at a rising edge: state=RUN, wait counter=0, stall_cnt=0, flush_cnt=0, mem_timeout=0, regardless of current state (including mid-MEM_WAIT or ERROR).
REQ-035 While rst=1, control outputs SHALL follow RUN-state rules from current inputs; counters SHALL not increment.

Verification
REQ-036 exe_mem_r_en=1, exe_dest=3, id_src1=3, 1 cycle -> hazard_detected=pc_freeze=ifid_freeze=1, pipe_freeze=0, stall_cnt 0->1.
REQ-037 exe_mem_r_en=1, exe_dest=0, id_src1=0 -> no stall; exe_dest=4, id_src2=4, id_two_src=0 -> no stall.
REQ-038 mem_req=1, mem_ready low 3 cycles then high -> pipe_freeze=1 for 3 cycles, RUN on 4th, stall_cnt=3.
REQ-039 mem_req=1, mem_ready held 0 for 20 cycles -> ERROR after 16 freeze cycles (1 RUN + 15 MEM_WAIT), mem_timeout=1 sticky; rst=1 one cycle -> RUN, all counters 0.
REQ-040 id_br_taken=1 with load_use=1 -> ifid_flush=0, hazard_detected=1; next cycle load_use=0 -> ifid_flush=1, flush_cnt=1.
REQ-041 Force stall_cnt to 0xFFFE, hold load_use 3 cycles -> stall_cnt=0xFFFF and holds.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller for a five-stage in-order core.
// Combines three stall/flush sources into the pipeline control signals:
//   - data-memory wait (freezes the whole pipe, escalates to a sticky error
//     when memory never answers),
//   - load-use dependency (holds PC and IF/ID, inserts a bubble into ID/EXE),
//   - taken branch resolved in ID (flushes IF/ID).
// Control outputs are combinational from the inputs and the registered state,
// so they take effect in the same cycle as the condition that causes them.
// Two 16-bit saturating counters record stall cycles and branch flushes.
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_LEN = 5,
    parameter int MEM_TIMEOUT  = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [REG_ADDR_LEN-1:0] id_src1,
    input  logic [REG_ADDR_LEN-1:0] id_src2,
    input  logic                    id_two_src,
    input  logic                    id_br_taken,
    input  logic [REG_ADDR_LEN-1:0] exe_dest,
    input  logic                    exe_mem_r_en,
    input  logic                    mem_req,
    input  logic                    mem_ready,
    output logic                    hazard_detected,
    output logic                    pc_freeze,
    output logic                    ifid_freeze,
    output logic                    ifid_flush,
    output logic                    pipe_freeze,
    output logic                    mem_timeout,
    output logic [15:0]             stall_cnt,
    output logic [15:0]             flush_cnt
);

    // The wait counter only needs to reach MEM_TIMEOUT-1.
    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    state_t            state_reg;
    logic [WAIT_W-1:0] wait_cnt_reg;
    logic [15:0]       stall_cnt_reg;
    logic [15:0]       flush_cnt_reg;

    logic in_run;
    logic in_wait;
    logic in_err;
    logic mem_freeze;
    logic load_use;

    // While reset is asserted the controller behaves as if it were in RUN,
    // so a stale MEM_WAIT/ERROR state cannot freeze the pipe during reset.
    assign in_run  = rst || (state_reg == RUN);
    assign in_wait = !rst && (state_reg == MEM_WAIT);
    assign in_err  = !rst && (state_reg == ERROR);

    assign mem_freeze = (in_run && mem_req && !mem_ready)
                      || (in_wait && !mem_ready)
                      || in_err;

    // Register 0 is hard-wired zero, so a load targeting it never creates a dependency.
    assign load_use = exe_mem_r_en && (exe_dest != '0)
                   && ((id_src1 == exe_dest) || (id_two_src && (id_src2 == exe_dest)));

    // Priority resolution: memory freeze, then load-use, then branch flush.
    // A branch suppressed by a stall is simply seen again next cycle.
    always_comb begin
        hazard_detected = 1'b0;
        pc_freeze       = 1'b0;
        ifid_freeze     = 1'b0;
        ifid_flush      = 1'b0;
        pipe_freeze     = 1'b0;
        if (mem_freeze) begin
            pc_freeze   = 1'b1;
            ifid_freeze = 1'b1;
            pipe_freeze = 1'b1;
        end else if (load_use) begin
            hazard_detected = 1'b1;
            pc_freeze       = 1'b1;
            ifid_freeze     = 1'b1;
        end else if (id_br_taken) begin
            ifid_flush = 1'b1;
        end
    end

    // Memory-wait FSM with timeout escalation; ERROR is only left through reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= RUN;
            wait_cnt_reg <= '0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (mem_req && !mem_ready) begin
                        state_reg    <= MEM_WAIT;
                        wait_cnt_reg <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        state_reg <= RUN;
                    end else if (wait_cnt_reg == WAIT_LAST) begin
                        state_reg <= ERROR;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
                    end
                end
                ERROR: begin
                    state_reg <= ERROR;
                end
                default: begin
                    state_reg <= RUN;
                end
            endcase
        end
    end

    // Saturating event counters; frozen while reset is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (pc_freeze && (stall_cnt_reg != 16'hFFFF)) begin
                stall_cnt_reg <= stall_cnt_reg + 16'd1;
            end
            if (ifid_flush && (flush_cnt_reg != 16'hFFFF)) begin
                flush_cnt_reg <= flush_cnt_reg + 16'd1;
            end
        end
    end

    assign mem_timeout = (state_reg == ERROR);
    assign stall_cnt   = stall_cnt_reg;
    assign flush_cnt   = flush_cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: table of combinational vectors,
// hand-written multi-cycle sequences, and randomized traffic compared against
// a behavioural model of the controller.
module tb_pipe_hazard_ctrl;

    localparam int AW      = 5;
    localparam int TIMEOUT = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] id_src1, id_src2, exe_dest;
    logic          id_two_src, id_br_taken, exe_mem_r_en, mem_req, mem_ready;
    logic          hazard_detected, pc_freeze, ifid_freeze, ifid_flush, pipe_freeze, mem_timeout;
    logic [15:0]   stall_cnt, flush_cnt;

    pipe_hazard_ctrl #(.REG_ADDR_LEN(AW), .MEM_TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
        .id_br_taken(id_br_taken), .exe_dest(exe_dest), .exe_mem_r_en(exe_mem_r_en),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .hazard_detected(hazard_detected), .pc_freeze(pc_freeze),
        .ifid_freeze(ifid_freeze), .ifid_flush(ifid_flush), .pipe_freeze(pipe_freeze),
        .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- behavioural model ----------------
    // mem_busy: a memory access is outstanding; waited: MEM_WAIT cycles already
    // spent with no answer; broken: memory timed out (sticky until reset).
    bit mem_busy;
    int waited;
    bit broken;
    int m_stall, m_flush;
    // expected control outputs for the current cycle
    bit e_haz, e_pc, e_ifz, e_fl, e_pipe;

    function automatic bit load_use_now();
        if (!exe_mem_r_en || exe_dest == 0) return 1'b0;
        if (id_src1 == exe_dest) return 1'b1;
        return id_two_src && (id_src2 == exe_dest);
    endfunction

    task automatic model_outputs();
        bit frz;
        bit busy_now  = !rst && mem_busy;
        bit broke_now = !rst && broken;
        frz = broke_now || (busy_now && !mem_ready) || (!busy_now && !broke_now && mem_req && !mem_ready);
        {e_haz, e_pc, e_ifz, e_fl, e_pipe} = 5'b0;
        if (frz) begin
            e_pc = 1; e_ifz = 1; e_pipe = 1;
        end else if (load_use_now()) begin
            e_haz = 1; e_pc = 1; e_ifz = 1;
        end else if (id_br_taken) begin
            e_fl = 1;
        end
    endtask

    task automatic model_clock();
        if (rst) begin
            mem_busy = 0; waited = 0; broken = 0; m_stall = 0; m_flush = 0;
            return;
        end
        if (e_pc && m_stall < 65535) m_stall++;
        if (e_fl && m_flush < 65535) m_flush++;
        if (broken) return;
        if (mem_busy) begin
            if (mem_ready) mem_busy = 0;
            else if (waited + 1 >= TIMEOUT) begin broken = 1; mem_busy = 0; end
            else waited++;
        end else if (mem_req && !mem_ready) begin
            mem_busy = 1; waited = 0;
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: inputs already driven; sample at negedge, compare to model.
    task automatic step(input bit do_chk);
        @(negedge clk);
        model_outputs();
        if (do_chk) begin
            chk("hazard_detected", int'(hazard_detected), int'(e_haz));
            chk("pc_freeze",       int'(pc_freeze),       int'(e_pc));
            chk("ifid_freeze",     int'(ifid_freeze),     int'(e_ifz));
            chk("ifid_flush",      int'(ifid_flush),      int'(e_fl));
            chk("pipe_freeze",     int'(pipe_freeze),     int'(e_pipe));
            chk("mem_timeout",     int'(mem_timeout),     int'(broken));
            chk("stall_cnt",       int'(stall_cnt),       m_stall);
            chk("flush_cnt",       int'(flush_cnt),       m_flush);
        end
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; id_src1 = 0; id_src2 = 0; id_two_src = 0; id_br_taken = 0;
        exe_dest = 0; exe_mem_r_en = 0; mem_req = 0; mem_ready = 1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        step(1);
        rst = 0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [AW-1:0] s1, s2, dst;
        logic two, br, ld, req, rdy;
        logic haz, pc, ifz, fl, pipe;
    } vec_t;

    vec_t vecs[10];

    initial begin
        // s1 s2 dst two br ld req rdy | haz pc ifz fl pipe
        vecs[0] = '{3, 0, 3, 0, 0, 1, 0, 1, 1, 1, 1, 0, 0}; // load-use on src1
        vecs[1] = '{0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0}; // dest r0 never stalls
        vecs[2] = '{1, 4, 4, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0}; // src2 unused
        vecs[3] = '{1, 4, 4, 1, 0, 1, 0, 1, 1, 1, 1, 0, 0}; // load-use on src2
        vecs[4] = '{5, 5, 5, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0}; // not a load
        vecs[5] = '{2, 2, 7, 1, 1, 1, 0, 1, 0, 0, 0, 1, 0}; // branch flush only
        vecs[6] = '{7, 2, 7, 0, 1, 1, 0, 1, 1, 1, 1, 0, 0}; // load-use beats branch
        vecs[7] = '{7, 2, 7, 0, 1, 1, 1, 1, 1, 1, 1, 0, 0}; // mem ready: no mem stall
        vecs[8] = '{9, 9, 9, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0}; // plain mem hit
        vecs[9] = '{0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 1, 0}; // branch
    end

    initial begin
        idle_inputs();
        rst = 1;
        step(0);
        step(1);
        rst = 0;
        chk("reset stall_cnt", int'(stall_cnt), 0);
        chk("reset flush_cnt", int'(flush_cnt), 0);
        chk("reset mem_timeout", int'(mem_timeout), 0);

        // Table-driven combinational checks (memory never stalls here).
        for (int i = 0; i < 10; i++) begin
            id_src1 = vecs[i].s1; id_src2 = vecs[i].s2; exe_dest = vecs[i].dst;
            id_two_src = vecs[i].two; id_br_taken = vecs[i].br; exe_mem_r_en = vecs[i].ld;
            mem_req = vecs[i].req; mem_ready = vecs[i].rdy;
            #1;
            chk($sformatf("vec%0d hazard", i), int'(hazard_detected), int'(vecs[i].haz));
            chk($sformatf("vec%0d pc_freeze", i), int'(pc_freeze), int'(vecs[i].pc));
            chk($sformatf("vec%0d ifid_freeze", i), int'(ifid_freeze), int'(vecs[i].ifz));
            chk($sformatf("vec%0d ifid_flush", i), int'(ifid_flush), int'(vecs[i].fl));
            chk($sformatf("vec%0d pipe_freeze", i), int'(pipe_freeze), int'(vecs[i].pipe));
            step(1);
            $display("vec %0d: haz=%0b pc=%0b ifz=%0b flush=%0b pipe=%0b", i,
                     hazard_detected, pc_freeze, ifid_freeze, ifid_flush, pipe_freeze);
        end

        // Single load-use cycle bumps stall_cnt 0 -> 1.
        do_reset();
        exe_mem_r_en = 1; exe_dest = 3; id_src1 = 3;
        step(1);
        idle_inputs();
        #1;
        chk("load-use stall_cnt", int'(stall_cnt), 1);
        $display("load-use single: stall_cnt=%0d", stall_cnt);

        // Memory answers after three wait cycles.
        do_reset();
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("memwait pipe_freeze", int'(pipe_freeze), 1);
            step(1);
        end
        mem_ready = 1;
        #1 chk("memwait release pipe_freeze", int'(pipe_freeze), 0);
        step(1);
        idle_inputs();
        #1 chk("memwait stall_cnt", int'(stall_cnt), 3);
        $display("mem wait 3: stall_cnt=%0d", stall_cnt);

        // Memory never answers: error after 1 RUN + 15 MEM_WAIT freeze cycles.
        do_reset();
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            chk($sformatf("timeout cyc%0d mem_timeout", i), int'(mem_timeout), (i >= 16) ? 1 : 0);
            chk($sformatf("timeout cyc%0d pipe_freeze", i), int'(pipe_freeze), 1);
            step(1);
        end
        idle_inputs();
        #1 chk("timeout sticky", int'(mem_timeout), 1);
        chk("timeout sticky freeze", int'(pipe_freeze), 1);
        step(1);
        rst = 1;
        #1 chk("rst overrides ERROR freeze", int'(pipe_freeze), 0);
        step(1);
        rst = 0;
        #1;
        chk("after rst mem_timeout", int'(mem_timeout), 0);
        chk("after rst stall_cnt", int'(stall_cnt), 0);
        chk("after rst flush_cnt", int'(flush_cnt), 0);
        $display("timeout seq: recovered mem_timeout=%0b stall_cnt=%0d", mem_timeout, stall_cnt);

        // Branch suppressed by load-use, then taken next cycle.
        do_reset();
        exe_mem_r_en = 1; exe_dest = 6; id_src1 = 6; id_br_taken = 1;
        #1 chk("br+lu ifid_flush", int'(ifid_flush), 0);
        chk("br+lu hazard", int'(hazard_detected), 1);
        step(1);
        exe_mem_r_en = 0;
        #1 chk("br retry ifid_flush", int'(ifid_flush), 1);
        step(1);
        idle_inputs();
        #1 chk("br flush_cnt", int'(flush_cnt), 1);
        $display("branch retry: flush_cnt=%0d", flush_cnt);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(0, 99) == 0);
            id_src1      = AW'($urandom_range(0, 3));
            id_src2      = AW'($urandom_range(0, 3));
            exe_dest     = AW'($urandom_range(0, 3));
            id_two_src   = 1'($urandom_range(0, 1));
            id_br_taken  = ($urandom_range(0, 3) == 0);
            exe_mem_r_en = 1'($urandom_range(0, 1));
            mem_req      = ($urandom_range(0, 3) == 0);
            // long low stretches now and then so timeouts also occur
            mem_ready    = ((i / 200) % 3 == 2) ? 1'b0 : ($urandom_range(0, 2) != 0);
            step(1);
            if (i % 250 == 0)
                $display("rand %0d: stall_cnt=%0d flush_cnt=%0d mem_timeout=%0b", i, stall_cnt, flush_cnt, mem_timeout);
        end

        // Saturation: hold a load-use stall long enough to wrap 16 bits.
        do_reset();
        exe_mem_r_en = 1; exe_dest = 2; id_src1 = 2;
        repeat (65534) @(posedge clk);
        #1;
        m_stall = 65534;
        chk("stall_cnt pre-sat", int'(stall_cnt), 16'hFFFE);
        for (int i = 0; i < 3; i++) step(1);
        #1 chk("stall_cnt saturated", int'(stall_cnt), 16'hFFFF);
        $display("saturation: stall_cnt=%0h", stall_cnt);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
